// File: rtl/serial_sub8.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first, with a
// start/busy/done handshake and result registers held until the next completion.
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] res_d;
    logic             last;

    // res_q holds the WIDTH-1 bits produced so far; the newest bit enters at
    // the top, so on the last edge {d_bit, res_q} is the complete difference.
    always_comb begin
        d_bit = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
        res_d = {d_bit, res_q};
        last  = (cnt_q == CW'(WIDTH - 1));
    end

    // NOTE: reset is synchronous and clears every register, datapath included,
    // so an aborted operation leaves no stale operand or partial result behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d[WIDTH-1:1];
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        ovf_q   <= (a_msb_q != b_msb_q) & (res_d[WIDTH-1] != a_msb_q);
                        zero_q  <= (res_d == '0);
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed bench for serial_sub8: latency, arithmetic flags, ignored start,
// back-to-back throughput and reset abort. Inputs driven and outputs sampled on negedge.
module tb_serial_sub8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;

    int checks = 0;
    int errors = 0;

    serial_sub8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then follow the operation to its done pulse.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input logic [7:0] ed, input logic eb,
                          input logic eo, input logic ez);
        int busy_cnt;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busycycles"}, busy_cnt, 8);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
        check({tag, "_zero"}, zero, ez);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_flags", {bout, ovf, zero}, 0);
        rst_n = 1'b1;

        run_op("sub_5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        run_op("sub_3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        run_op("bin_0_0",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("zero_2a",   8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Start during RUN is ignored; results hold until completion.
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h55; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_hold_diff", diff, 8'h00);
        check("ign_hold_zero", zero, 1);
        done_cnt = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("ign_diff", diff, 8'h0F);
                    check("ign_zero", zero, 0);
                end
            end
            @(negedge clk);
        end
        check("ign_done_count", done_cnt, 1);
        check("ign_idle", busy, 0);

        // Start held high: two operations, done pulses 9 cycles apart.
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h10; b = 8'h01;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done1", done, 1);
        check("b2b_diff1", diff, 8'h02);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        start = 1'b0;
        check("b2b_done2", done, 1);
        check("b2b_spacing", n, 9);
        check("b2b_diff2", diff, 8'h0F);
        @(negedge clk);
        check("b2b_stop", busy, 0);

        // Reset during the fourth busy cycle aborts the operation.
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_flags", {done, bout, ovf, zero}, 0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", done_cnt, 0);
        run_op("after_rst", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
